load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/mips_mem_pkg.sv | 23 ++
 rtl/mem_lane_format.sv | 51 +++++
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states,
// and the default data memory depth.
package mips_mem_pkg;

  localparam int MEM_WORDS_DEF = 21;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    STORE  = 3'd4,
    DONE   = 3'd5
  } lsu_state_e;

endpackage

// File: rtl/mem_lane_format.sv
// Big-endian lane extraction for loads and lane merge for sub-word
// stores; purely combinational.
module mem_lane_format
  import mips_mem_pkg::*;
(
  input  mem_size_e   size,
  input  logic        is_signed,
  input  logic [1:0]  offset,
  input  logic [31:0] rd_word,
  input  logic [31:0] base_word,
  input  logic [31:0] wr_data,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [31:0] shifted;

  always_comb begin
    sh       = 5'd0;
    shifted  = rd_word;
    load_val = rd_word;
    merged   = wr_data;
    unique case (size)
      SZ_BYTE: begin
        // offset 0 lives in the top byte
        sh       = {~offset, 3'b000};
        shifted  = rd_word >> sh;
        load_val = {{24{is_signed & shifted[7]}}, shifted[7:0]};
        merged   = (base_word & ~(32'h0000_00FF << sh))
                 | ({24'h0, wr_data[7:0]} << sh);
      end
      SZ_HALF: begin
        sh       = {~offset[1], 4'b0000};
        shifted  = rd_word >> sh;
        load_val = {{16{is_signed & shifted[15]}}, shifted[15:0]};
        merged   = (base_word & ~(32'h0000_FFFF << sh))
                 | ({16'h0, wr_data[15:0]} << sh);
      end
      SZ_WORD: begin
        load_val = rd_word;
        merged   = wr_data;
      end
      SZ_BAD: begin
        load_val = rd_word;
        merged   = wr_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer in front of a word-wide data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memSigned,
  input  logic [31:0] Address,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        addrError,
  output logic        dm_memRead,
  output logic        dm_memWrite,
  output logic [31:0] dm_Address,
  output logic [31:0] dm_write_data,
  input  logic [31:0] dm_read_data
);

  localparam logic [29:0] WORD_LIM = 30'(MEM_WORDS);

  lsu_state_e  state_q;
  lsu_state_e  state_d;
  mem_size_e   size;
  logic        err_q;
  logic [31:0] merge_q;
  logic        req;
  logic        bad;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign size = mem_size_e'(memSize);
  assign req  = memRead | memWrite;

  always_comb begin
    bad = 1'b0;
    if (memRead && memWrite)            bad = 1'b1;
    if (size == SZ_BAD)                 bad = 1'b1;
    if (size == SZ_HALF && Address[0])  bad = 1'b1;
    if (size == SZ_WORD && Address[1:0] != 2'b00)
                                        bad = 1'b1;
    if (Address[31:2] >= WORD_LIM)      bad = 1'b1;
  end

  mem_lane_format u_fmt (
    .size      (size),
    .is_signed (memSigned),
    .offset    (Address[1:0]),
    .rd_word   (dm_read_data),
    .base_word (merge_q),
    .wr_data   (write_data),
    .load_val  (load_val),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      merge_q   <= 32'h0;
      load_data <= 32'h0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            err_q <= bad;
            if (bad) load_data <= 32'h0;
          end
        end
        LOAD:    load_data <= load_val;
        RMW_RD:  merge_q   <= dm_read_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    dm_memRead    = 1'b0;
    dm_memWrite   = 1'b0;
    dm_write_data = write_data;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (bad)                  state_d = DONE;
          else if (memRead)         state_d = LOAD;
          else if (size == SZ_WORD) state_d = STORE;
          else                      state_d = RMW_RD;
        end
      end
      LOAD: begin
        dm_memRead = 1'b1;
        state_d    = DONE;
      end
      RMW_RD: begin
        dm_memRead = 1'b1;
        state_d    = RMW_WR;
      end
      RMW_WR: begin
        dm_memWrite   = 1'b1;
        dm_write_data = merged;
        state_d       = DONE;
      end
      STORE: begin
        dm_memWrite = 1'b1;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done       = (state_q == DONE);
  assign addrError  = done & err_q;
  assign stall      = req & ~done;
  assign dm_Address = {2'b00, Address[31:2]};

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-addressed
// big-endian memory model.
module tb_load_store_unit;

  localparam int NW = 21;
  localparam int NB = NW * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  memSize;
  logic        memSigned;
  logic [31:0] Address;
  logic [31:0] write_data;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        addrError;
  logic        dm_memRead;
  logic        dm_memWrite;
  logic [31:0] dm_Address;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;

  logic [31:0] env_mem [NW];
  logic [7:0]  ref_b   [NB];
  logic [31:0] last_load;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_count = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(NW)) dut (
    .clk           (clk),
    .reset         (reset),
    .memRead       (memRead),
    .memWrite      (memWrite),
    .memSize       (memSize),
    .memSigned     (memSigned),
    .Address       (Address),
    .write_data    (write_data),
    .stall         (stall),
    .load_data     (load_data),
    .done          (done),
    .addrError     (addrError),
    .dm_memRead    (dm_memRead),
    .dm_memWrite   (dm_memWrite),
    .dm_Address    (dm_Address),
    .dm_write_data (dm_write_data),
    .dm_read_data  (dm_read_data)
  );

  assign dm_read_data = (dm_Address < NW) ? env_mem[dm_Address[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (dm_memWrite) begin
      wr_count <= wr_count + 1;
      if (dm_Address < NW) env_mem[dm_Address[4:0]] <= dm_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[idx*4], ref_b[idx*4+1], ref_b[idx*4+2], ref_b[idx*4+3]};
  endfunction

  function automatic bit ref_bad(input logic rd, input logic wr,
                                 input logic [1:0] sz, input logic [31:0] a);
    if (rd && wr) return 1;
    if (sz == 2'd3) return 1;
    if (sz == 2'd1 && a % 2 != 0) return 1;
    if (sz == 2'd2 && a % 4 != 0) return 1;
    if (a / 4 >= NW) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz,
                                           input logic sg, input int a);
    logic [31:0] v;
    int nbytes;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v = 0;
    for (int i = 0; i < nbytes; i++) v = (v << 8) | 32'(ref_b[a + i]);
    if (sg && nbytes == 1 && v >= 32'h80)   v = v - 32'h100;
    if (sg && nbytes == 2 && v >= 32'h8000) v = v - 32'h10000;
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input int a,
                           input logic [31:0] wd);
    int nbytes;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < nbytes; i++)
      ref_b[a + i] = 8'((wd >> (8 * (nbytes - 1 - i))) & 32'hFF);
  endtask

  // Entered and left just after a rising edge.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd);
    bit bad, fin, strobe, both, stall_lo;
    int lat, exp_lat;
    bad = ref_bad(rd, wr, sz, a);
    exp_lat = bad ? 1 : (wr && sz != 2'd2) ? 3 : 2;
    memRead = rd; memWrite = wr; memSize = sz;
    memSigned = sg; Address = a; write_data = wd;
    #1;
    chk("stall_c0", 32'(stall), 32'd1);
    strobe = dm_memRead | dm_memWrite;
    both = 0; fin = 0; stall_lo = 0; lat = 0;
    while (!fin && lat < 8) begin
      @(posedge clk); #2;
      lat++;
      if (dm_memRead && dm_memWrite) both = 1;
      if (done) fin = 1;
      else begin
        if (dm_memRead || dm_memWrite) strobe = 1;
        if (!stall) stall_lo = 1;
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("stall_busy", 32'(stall_lo), 32'd0);
    chk("strobe_excl", 32'(both), 32'd0);
    if (fin) begin
      chk("stall_done", 32'(stall), 32'd0);
      chk("addr_error", 32'(addrError), 32'(bad));
      chk("done_strobes", {30'h0, dm_memRead, dm_memWrite}, 32'h0);
    end
    if (bad) begin
      chk("bad_strobes", 32'(strobe), 32'd0);
      last_load = 32'h0;
    end else if (rd) begin
      last_load = ref_load(sz, sg, int'(a));
    end else begin
      ref_store(sz, int'(a), wd);
      chk("mem_word", env_mem[a[6:2]], ref_word(int'(a / 4)));
    end
    chk("load_data", load_data, last_load);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      env_mem[i] = (i == 2) ? 32'h8 : (i == 3) ? 32'h6 : $urandom;
      for (int j = 0; j < 4; j++)
        ref_b[i*4+j] = 8'(env_mem[i] >> (8 * (3 - j)));
    end
    last_load = 32'h0;
    reset = 1'b1; memRead = 1'b1; memWrite = 1'b0; memSize = 2'd2;
    memSigned = 1'b0; Address = 32'h0; write_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(addrError), 32'd0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_strobes", {30'h0, dm_memRead, dm_memWrite}, 32'h0);
    reset = 1'b0; memRead = 1'b0;
    @(posedge clk); #1;

    access(1, 0, 2'd2, 0, 32'h08, 32'h0);
    chk("lw_08", load_data, 32'h8);
    access(0, 1, 2'd0, 0, 32'h0D, 32'hAB);
    chk("sb_0d", env_mem[3], 32'h00AB0006);
    access(0, 1, 2'd2, 0, 32'h10, 32'h80FF1234);
    access(1, 0, 2'd0, 1, 32'h10, 32'h0);
    chk("lb_10", load_data, 32'hFFFFFF80);
    access(1, 0, 2'd0, 0, 32'h10, 32'h0);
    chk("lbu_10", load_data, 32'h00000080);
    access(1, 0, 2'd1, 1, 32'h12, 32'h0);
    chk("lh_12", load_data, 32'h00001234);
    access(1, 0, 2'd1, 1, 32'h10, 32'h0);
    chk("lh_10", load_data, 32'hFFFF80FF);
    access(1, 0, 2'd2, 0, 32'h06, 32'h0);
    access(1, 0, 2'd2, 0, 32'h54, 32'h0);
    access(1, 1, 2'd2, 0, 32'h04, 32'h0);
    access(1, 0, 2'd3, 0, 32'h04, 32'h0);
    access(0, 1, 2'd1, 0, 32'h0B, 32'h1);

    // reset lands while the halfword store sits in its read phase
    wr_count = 0;
    memRead = 1'b0; memWrite = 1'b1; memSize = 2'd1;
    memSigned = 1'b0; Address = 32'h0; write_data = 32'h0002;
    @(posedge clk); #1;
    chk("rmw_rd_seen", 32'(dm_memRead), 32'd1);
    reset = 1'b1; memWrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_wr", 32'(wr_count), 32'd0);
    chk("abort_mem", env_mem[0], ref_word(0));
    chk("abort_done", 32'(done), 32'd0);
    last_load = 32'h0;
    chk("abort_load", load_data, last_load);

    for (int n = 0; n < 200; n++) begin
      logic rd, wr;
      logic [1:0] sz;
      int pick;
      pick = $urandom_range(0, 19);
      rd = (pick < 9) || (pick == 19);
      wr = !rd || (pick == 19);
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      access(rd, wr, sz, 1'($urandom), 32'($urandom_range(0, 95)), $urandom);
    end
    memRead = 1'b0; memWrite = 1'b0;

    for (int i = 0; i < NW; i++) chk("final_mem", env_mem[i], ref_word(i));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
